// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-ported memory (req/gnt/rvalid handshake) between the
//   instruction-fetch port and the data port of the core. One transaction is
//   outstanding at a time. Data has priority; a starvation counter forces a
//   fetch grant after STARVE_LIMIT consecutive data grants made while fetch
//   was waiting. Data accesses are lane-aligned: the address is word-aligned
//   and byte enables / write data / read data are shifted by addr[1:0].
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   i_req/i_addr              fetch request; i_rvalid/i_rdata response pulse + word
//   d_req/d_we/d_addr/
//   d_wdata/d_be              data request, right-justified data and enables
//   d_rvalid/d_rdata          data response pulse + right-justified load data
//   m_req/m_we/m_addr/
//   m_wdata/m_be              memory request, word-aligned and lane-shifted
//   m_gnt/m_rvalid/m_rdata    memory accept, response strobe, read word
//
// All memory-side and response outputs come straight from registers.

module unified_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_be,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [31:0]       m_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            r_state;
    state_t            w_next;
    logic              r_owner_d;   // 1 = data port owns the current transaction
    logic [1:0]        r_off;       // data byte offset, kept for the load shift
    logic [3:0]        r_starve;
    logic              r_m_req;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [31:0]       r_m_wdata;
    logic [3:0]        r_m_be;
    logic              r_i_rvalid;
    logic [31:0]       r_i_rdata;
    logic              r_d_rvalid;
    logic [31:0]       r_d_rdata;
    logic              w_grant_d;
    logic              w_grant_i;

    // Fetch addresses are always word-aligned on the bus; low bits are dropped.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, i_addr[1:0]};

    // Data wins a tie unless fetch has waited through LIMIT data grants.
    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (d_req && !(i_req && r_starve == LIMIT))
            w_grant_d = 1'b1;
        else if (i_req)
            w_grant_i = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // DONE always returns to IDLE without arbitrating, so a requester that
    // drops req on seeing rvalid is never re-issued.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_d || w_grant_i) w_next = S_REQ;
            S_REQ:   if (m_gnt)                  w_next = S_RESP;
            S_RESP:  if (m_rvalid)               w_next = S_DONE;
            S_DONE:                              w_next = S_IDLE;
            default:                             w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_d  <= 1'b0;
            r_off      <= '0;
            r_starve   <= '0;
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_m_be     <= '0;
            r_i_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= '0;
        end else begin
            // Response strobes are single-cycle: set on the RESP->DONE edge only.
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!i_req || w_grant_i)
                        r_starve <= '0;
                    else if (w_grant_d && r_starve != 4'hF)
                        r_starve <= r_starve + 4'd1;

                    if (w_grant_d) begin
                        r_owner_d <= 1'b1;
                        r_off     <= d_addr[1:0];
                        r_m_req   <= 1'b1;
                        r_m_we    <= d_we;
                        r_m_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
                        r_m_be    <= d_be << d_addr[1:0];
                        r_m_wdata <= d_wdata << {d_addr[1:0], 3'b000};
                    end else if (w_grant_i) begin
                        r_owner_d <= 1'b0;
                        r_off     <= '0;
                        r_m_req   <= 1'b1;
                        r_m_we    <= 1'b0;
                        r_m_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                        r_m_be    <= 4'hF;
                        r_m_wdata <= '0;
                    end
                end
                S_REQ: begin
                    if (m_gnt)
                        r_m_req <= 1'b0;
                end
                S_RESP: begin
                    if (m_rvalid) begin
                        if (r_owner_d) begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= m_rdata >> {r_off, 3'b000};
                        end else begin
                            r_i_rvalid <= 1'b1;
                            r_i_rdata  <= m_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_req    = r_m_req;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign m_be     = r_m_be;
    assign i_rvalid = r_i_rvalid;
    assign i_rdata  = r_i_rdata;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;

endmodule
